reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 20 ++
 rtl/reset_sequencer_sync_2ff.sv | 28 ++
 rtl/reset_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default
// ack timeout and the ack timer width.
package reset_seq_pkg;

    // Default number of cycles a released domain has to acknowledge.
    localparam int unsigned TMO_DEFAULT = 16;

    // Ack timer width; it saturates at all-ones and never wraps.
    localparam int unsigned ACK_TMR_W = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DLY = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reusable for any asynchronous reset-good input that must be brought into
// the clk domain. Both flops clear on the synchronous active-low reset.
//   clk    : destination clock
//   resetb : synchronous active-low reset
//   d      : asynchronous input
//   q      : synchronized output, two clk edges of latency
module sync_2ff (
    input  logic clk,
    input  logic resetb,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_DOM downstream reset domains one after the
// other, domain 0 first. Each domain waits its programmed delay, is released,
// and must acknowledge within TMO cycles before the next domain starts.
// A missing ack parks the block in an error state with every domain held in
// reset. Losing power-good or a software request restarts from scratch.
//   clk        : system clock
//   resetb     : synchronous active-low reset
//   porb_in    : asynchronous active-low power-on-reset-good
//   sw_rst_req : single-cycle request to rerun the full sequence
//   dly_cfg    : per-domain release delays, domain i at [i*DLY_W +: DLY_W]
//   dom_ack    : per-domain ready acknowledge (level)
//   dom_rstb   : per-domain active-low reset (registered)
//   seq_done   : all domains released (registered)
//   seq_err    : ack timeout seen, held until restart (registered)
//   cur_dom    : index of the domain currently being sequenced (registered)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter  int unsigned NUM_DOM = 4,
    parameter  int unsigned DLY_W   = 4,
    parameter  int unsigned TMO     = TMO_DEFAULT,
    localparam int unsigned CUR_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     porb_in,
    input  logic                     sw_rst_req,
    input  logic [NUM_DOM*DLY_W-1:0] dly_cfg,
    input  logic [NUM_DOM-1:0]       dom_ack,
    output logic [NUM_DOM-1:0]       dom_rstb,
    output logic                     seq_done,
    output logic                     seq_err,
    output logic [CUR_W-1:0]         cur_dom
);

    localparam int unsigned          CFG_W    = NUM_DOM * DLY_W;
    localparam logic [ACK_TMR_W-1:0] TMO_LAST = ACK_TMR_W'(TMO - 1);
    localparam logic [ACK_TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [CUR_W-1:0]     LAST_DOM = CUR_W'(NUM_DOM - 1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [DLY_W-1:0]     dly_cnt;
    logic [DLY_W-1:0]     dly_cnt_nxt;
    logic [ACK_TMR_W-1:0] ack_tmr;
    logic [ACK_TMR_W-1:0] ack_tmr_nxt;
    logic [NUM_DOM-1:0]   rstb_nxt;
    logic                 done_nxt;
    logic                 err_nxt;
    logic [CUR_W-1:0]     cur_nxt;
    logic [CUR_W-1:0]     cur_inc;
    logic                 porb_s;
    logic                 abort;

    // Delay field for a given domain index.
    function automatic logic [DLY_W-1:0] dly_field(
        input logic [CFG_W-1:0] cfg,
        input logic [CUR_W-1:0] idx
    );
        return cfg[32'(idx) * DLY_W +: DLY_W];
    endfunction

    // Bring the asynchronous power-good into the clk domain.
    sync_2ff u_porb_sync (
        .clk    (clk),
        .resetb (resetb),
        .d      (porb_in),
        .q      (porb_s)
    );

    assign cur_inc = cur_dom + CUR_W'(1);

    // Any active state is abandoned when power-good drops or software asks.
    assign abort = (state != ST_IDLE) && (!porb_s || sw_rst_req);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state    <= ST_IDLE;
            dly_cnt  <= '0;
            ack_tmr  <= '0;
            dom_rstb <= '0;
            seq_done <= 1'b0;
            seq_err  <= 1'b0;
            cur_dom  <= '0;
        end else begin
            state    <= state_nxt;
            dly_cnt  <= dly_cnt_nxt;
            ack_tmr  <= ack_tmr_nxt;
            dom_rstb <= rstb_nxt;
            seq_done <= done_nxt;
            seq_err  <= err_nxt;
            cur_dom  <= cur_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        ack_tmr_nxt = ack_tmr;
        rstb_nxt    = dom_rstb;
        done_nxt    = seq_done;
        err_nxt     = seq_err;
        cur_nxt     = cur_dom;

        if (abort) begin
            state_nxt   = ST_IDLE;
            dly_cnt_nxt = '0;
            ack_tmr_nxt = '0;
            rstb_nxt    = '0;
            done_nxt    = 1'b0;
            err_nxt     = 1'b0;
            cur_nxt     = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    rstb_nxt = '0;
                    done_nxt = 1'b0;
                    err_nxt  = 1'b0;
                    cur_nxt  = '0;
                    // A software request here only holds IDLE one more cycle.
                    if (porb_s && !sw_rst_req) begin
                        dly_cnt_nxt = dly_field(dly_cfg, CUR_W'(0));
                        state_nxt   = ST_WAIT_DLY;
                    end
                end

                ST_WAIT_DLY: begin
                    if (dly_cnt != '0) begin
                        dly_cnt_nxt = dly_cnt - DLY_W'(1);
                    end else begin
                        // Earlier domains keep their release bits.
                        rstb_nxt[cur_dom] = 1'b1;
                        ack_tmr_nxt       = '0;
                        state_nxt         = ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    // Ack is checked before the timeout so a same-cycle ack wins.
                    if (dom_ack[cur_dom]) begin
                        if (cur_dom == LAST_DOM) begin
                            rstb_nxt  = '1;
                            done_nxt  = 1'b1;
                            state_nxt = ST_DONE;
                        end else begin
                            cur_nxt     = cur_inc;
                            dly_cnt_nxt = dly_field(dly_cfg, cur_inc);
                            state_nxt   = ST_WAIT_DLY;
                        end
                    end else if (ack_tmr == TMO_LAST) begin
                        rstb_nxt  = '0;
                        err_nxt   = 1'b1;
                        state_nxt = ST_ERR;
                    end else if (ack_tmr != TMR_MAX) begin
                        ack_tmr_nxt = ack_tmr + ACK_TMR_W'(1);
                    end
                end

                ST_DONE: begin
                    // Acks are no longer watched once every domain is out.
                    rstb_nxt = '1;
                    done_nxt = 1'b1;
                end

                ST_ERR: begin
                    rstb_nxt = '0;
                    err_nxt  = 1'b1;
                end

                default: begin
                    state_nxt = ST_IDLE;
                    rstb_nxt  = '0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    cur_nxt   = '0;
                end
            endcase
        end
    end

endmodule
